// File: rtl/ethsim_pkg.sv
// ---------------------------------------------------------------------------
// ethsim_pkg
// Shared definitions for the 10G simulation datapath: AXIS widths and the
// state type of the TX frame arbiter.
// No ports (package).
// ---------------------------------------------------------------------------
package ethsim_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    // GAP is only reachable when the inter-frame gap feature is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Single-entry AXIS output register. Accepts a beat whenever the register is
// empty or being drained in the same cycle; payload is held stable while the
// downstream stalls.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake
//   in_data_i/keep/last/user     upstream payload
//   out_valid_o / out_ready_i    downstream handshake
//   out_data_o/keep/last/user    registered payload
// ---------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [KEEP_W-1:0] in_keep_i,
    input  logic              in_last_i,
    input  logic              in_user_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [KEEP_W-1:0] out_keep_o,
    output logic              out_last_o,
    output logic              out_user_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;
    logic              user_q;

    assign in_ready_o = ~valid_q | out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            keep_q  <= in_keep_i;
            last_q  <= in_last_i;
            user_q  <= in_user_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;
    assign out_user_o  = user_q;

endmodule

// File: rtl/axis_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_tx_frame_arbiter
// 2:1 frame-granular round-robin arbiter in front of the MAC TX AXIS port.
// A grant is held from the first beat of a frame to its tlast, so beats of
// the two requesters never interleave. One registered output stage.
//
// Build option: define ARB_IFG_EN to force IFG_CYCLES idle cycles (GAP state)
// after every frame; without it a frame end returns straight to IDLE.
//
// Ports:
//   clk156, rst                 sole clock, synchronous active-high reset
//   s0_axis_tx_*                requester 0 AXIS slave
//   s1_axis_tx_*                requester 1 AXIS slave
//   m_axis_tx_*                 shared AXIS master (registered)
//   grant                       one-hot current owner, 2'b00 when none
//   frame_cnt0, frame_cnt1      frames forwarded per requester, wrapping
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requesters (1 cycle)
// GRANT0 | requester 0 owns the output until its tlast is accepted
// GRANT1 | requester 1 owns the output until its tlast is accepted
// GAP    | forced inter-frame gap, both readies low (ARB_IFG_EN only)
// ---------------------------------------------------------------------------
module axis_tx_frame_arbiter #(
    parameter int DATA_W = ethsim_pkg::DATA_W,
    parameter int KEEP_W = ethsim_pkg::KEEP_W
`ifdef ARB_IFG_EN
   ,parameter int IFG_CYCLES = 2
`endif
) (
    input  logic              clk156,
    input  logic              rst,

    input  logic              s0_axis_tx_tvalid,
    output logic              s0_axis_tx_tready,
    input  logic [DATA_W-1:0] s0_axis_tx_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tx_tkeep,
    input  logic              s0_axis_tx_tlast,
    input  logic              s0_axis_tx_tuser,

    input  logic              s1_axis_tx_tvalid,
    output logic              s1_axis_tx_tready,
    input  logic [DATA_W-1:0] s1_axis_tx_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tx_tkeep,
    input  logic              s1_axis_tx_tlast,
    input  logic              s1_axis_tx_tuser,

    output logic              m_axis_tx_tvalid,
    input  logic              m_axis_tx_tready,
    output logic [DATA_W-1:0] m_axis_tx_tdata,
    output logic [KEEP_W-1:0] m_axis_tx_tkeep,
    output logic              m_axis_tx_tlast,
    output logic              m_axis_tx_tuser,

    output logic [1:0]        grant,
    output logic [15:0]       frame_cnt0,
    output logic [15:0]       frame_cnt1
);

    import ethsim_pkg::*;

`ifdef ARB_IFG_EN
    localparam arb_state_t POST_FRAME = GAP;
    localparam logic [3:0] GAP_LOAD   = 4'(IFG_CYCLES - 1);
    logic [3:0] gap_cnt_q;
`else
    localparam arb_state_t POST_FRAME = IDLE;
`endif

    arb_state_t  state_q;
    logic        last_grant_q;
    logic [15:0] frame_cnt0_q;
    logic [15:0] frame_cnt1_q;

    logic              slice_ready;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_last;
    logic              sel_user;
    logic              acc0;
    logic              acc1;

    assign s0_axis_tx_tready = (state_q == GRANT0) & slice_ready;
    assign s1_axis_tx_tready = (state_q == GRANT1) & slice_ready;
    assign acc0 = s0_axis_tx_tvalid & s0_axis_tx_tready;
    assign acc1 = s1_axis_tx_tvalid & s1_axis_tx_tready;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = s0_axis_tx_tdata;
        sel_keep  = s0_axis_tx_tkeep;
        sel_last  = s0_axis_tx_tlast;
        sel_user  = s0_axis_tx_tuser;
        if (state_q == GRANT0) begin
            sel_valid = s0_axis_tx_tvalid;
        end else if (state_q == GRANT1) begin
            sel_valid = s1_axis_tx_tvalid;
            sel_data  = s1_axis_tx_tdata;
            sel_keep  = s1_axis_tx_tkeep;
            sel_last  = s1_axis_tx_tlast;
            sel_user  = s1_axis_tx_tuser;
        end
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;   // port 0 wins the first contested arbitration
            frame_cnt0_q <= '0;
            frame_cnt1_q <= '0;
`ifdef ARB_IFG_EN
            gap_cnt_q    <= GAP_LOAD;
`endif
        end else begin
`ifdef ARB_IFG_EN
            // Counter is parked at the load value outside GAP so it is ready
            // the moment a frame ends.
            if (state_q == GAP) gap_cnt_q <= gap_cnt_q - 4'd1;
            else                gap_cnt_q <= GAP_LOAD;
`endif
            case (state_q)
                IDLE: begin
                    if (s0_axis_tx_tvalid && (!s1_axis_tx_tvalid || last_grant_q)) begin
                        state_q      <= GRANT0;
                        last_grant_q <= 1'b0;
                    end else if (s1_axis_tx_tvalid) begin
                        state_q      <= GRANT1;
                        last_grant_q <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (acc0 && s0_axis_tx_tlast) begin
                        frame_cnt0_q <= frame_cnt0_q + 16'd1;
                        state_q      <= POST_FRAME;
                    end
                end
                GRANT1: begin
                    if (acc1 && s1_axis_tx_tlast) begin
                        frame_cnt1_q <= frame_cnt1_q + 16'd1;
                        state_q      <= POST_FRAME;
                    end
                end
`ifdef ARB_IFG_EN
                GAP: begin
                    if (gap_cnt_q == 4'd0) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant      = {state_q == GRANT1, state_q == GRANT0};
    assign frame_cnt0 = frame_cnt0_q;
    assign frame_cnt1 = frame_cnt1_q;

    axis_reg_slice #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_out_slice (
        .clk_i       (clk156),
        .rst_i       (rst),
        .in_valid_i  (sel_valid),
        .in_ready_o  (slice_ready),
        .in_data_i   (sel_data),
        .in_keep_i   (sel_keep),
        .in_last_i   (sel_last),
        .in_user_i   (sel_user),
        .out_valid_o (m_axis_tx_tvalid),
        .out_ready_i (m_axis_tx_tready),
        .out_data_o  (m_axis_tx_tdata),
        .out_keep_o  (m_axis_tx_tkeep),
        .out_last_o  (m_axis_tx_tlast),
        .out_user_o  (m_axis_tx_tuser)
    );

endmodule
